// File: rtl/serial_addr_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_addr_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_addr.sv
// Gate-level half adder primitive: sum is the XOR and carry the AND of
// the two input bits.
module half_addr (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    xor g_sum   (s, a, b);
    and g_carry (c, a, b);

endmodule

// File: rtl/serial_addr_full_addr.sv
// Gate-level full adder built from two half adders; the two partial
// carries can never both be high, so a plain OR merges them.
module full_addr (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    half_addr u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    half_addr u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    or g_carry (co, c1, c2);

endmodule

// File: rtl/serial_addr.sv
// Bit-serial adder: one full-adder cell plus a carry flop processes the
// operands LSB first, one bit per clock, under a start/busy/done handshake.
module serial_addr
    import serial_addr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_r;
    logic [CW-1:0]    cnt;
    logic             fs;
    logic             fc;

    full_addr u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c_r),
        .s  (fs),
        .co (fc)
    );

    // Handshake FSM and serial datapath; sum/cout only load on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sr  <= in1;
                        b_sr  <= in2;
                        c_r   <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= {fs, s_sr[WIDTH-1:1]};
                    c_r  <= fc;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {fs, s_sr[WIDTH-1:1]};
                        cout  <= fc;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addr.sv
// Testbench for serial_addr: table of directed vectors, hand-written
// handshake corner cases, a WIDTH=4 instance, and randomised back-to-back
// operations checked against plain integer addition.
module tb_serial_addr;

    localparam int W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start4;
    logic [3:0]   in1_4;
    logic [3:0]   in2_4;
    logic         cin4;
    logic         busy4;
    logic         done4;
    logic [3:0]   sum4;
    logic         cout4;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] lastSum  = '0;
    logic       lastCout = 1'b0;

    serial_addr #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_addr #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in1(in1_4), .in2(in2_4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        else
            passCount++;
    endtask

    // Issue one operation on the 8-bit instance and wait for its done pulse;
    // inputs are scrambled after capture and output stability is watched.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input string tag, output logic [7:0] gs, output logic gc,
                                 output int lat, output int bc);
        int unstable;
        unstable = 0;
        @(negedge clk);
        in1 = a; in2 = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1 = 8'($urandom); in2 = 8'($urandom); cin = 1'($urandom);
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            if (sum !== lastSum || cout !== lastCout) unstable++;
            @(negedge clk);
            lat++;
        end
        gs = sum;
        gc = cout;
        checkOutput({tag, " stable"}, 32'(unstable), 32'd0);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        lastSum  = sum;
        lastCout = cout;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] gs;
        logic       gc;
        int         lat;
        int         bc;
        int         extraDone;
        logic [8:0] expTotal;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
        start4 = 1'b0; in1_4 = '0; in2_4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        checkOutput("reset busy4", 32'(busy4), 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i), gs, gc, lat, bc);
            checkOutput($sformatf("vec%0d sum", i), 32'(gs), 32'(vecs[i].expSum));
            checkOutput($sformatf("vec%0d cout", i), 32'(gc), 32'(vecs[i].expCout));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(bc), 32'd8);
            @(negedge clk);
            checkOutput($sformatf("vec%0d done width", i), 32'(done), 32'd0);
        end

        // Start during RUN cycle 3 is ignored
        @(negedge clk);
        in1 = 8'h10; in2 = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in1 = 8'hFF; in2 = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignored start latency", 32'(lat), 32'd9);
        checkOutput("ignored start sum", 32'(sum), 32'h30);
        checkOutput("ignored start cout", 32'(cout), 32'd0);
        extraDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        checkOutput("ignored start no second done", 32'(extraDone), 32'd0);

        // Reset during RUN cycle 4 aborts the operation
        @(negedge clk);
        in1 = 8'h77; in2 = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort sum", 32'(sum), 32'd0);
        checkOutput("abort cout", 32'(cout), 32'd0);
        extraDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        checkOutput("abort no done", 32'(extraDone), 32'd0);
        lastSum = '0;
        lastCout = 1'b0;
        applyStimulus(8'h01, 8'h01, 1'b0, "post-abort", gs, gc, lat, bc);
        checkOutput("post-abort sum", 32'(gs), 32'h02);
        checkOutput("post-abort cout", 32'(gc), 32'd0);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; in1 = 8'h12; in2 = 8'h34;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("rst+start busy", 32'(busy), 32'd0);
        extraDone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        checkOutput("rst+start no done", 32'(extraDone), 32'd0);
        lastSum = '0;
        lastCout = 1'b0;

        // WIDTH=4 instance
        @(negedge clk);
        in1_4 = 4'hF; in2_4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("w4 latency", 32'(lat), 32'd5);
        checkOutput("w4 sum", 32'(sum4), 32'hF);
        checkOutput("w4 cout", 32'(cout4), 32'd1);
        @(negedge clk);
        in1_4 = 4'h9; in2_4 = 4'h4; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("w4b sum", 32'(sum4), 32'hD);
        checkOutput("w4b cout", 32'(cout4), 32'd0);

        // Randomised back-to-back operations at the minimum interval
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            expTotal = 9'(ra) + 9'(rb) + 9'(rc);
            applyStimulus(ra, rb, rc, $sformatf("rand%0d", i), gs, gc, lat, bc);
            checkOutput($sformatf("rand%0d result", i), 32'({gc, gs}), 32'(expTotal));
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'd9);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
